// File: rtl/status_array_port_arbiter.sv
// status_array_port_arbiter: status array SRAM port arbiter, init zero-fill stream first, then FIFO'd client traffic.
// Define STATUS_ARB_BYPASS_EN to let RUN-state requests skip an empty FIFO.
module status_array_port_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int ROW_WIDTH  = 8,
  parameter int NUM_BLOCKS = 4,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  gated_clk,
  input  logic                  arst_n,
  input  logic [ADDR_WIDTH-1:0] i_init_addr,
  input  logic [ROW_WIDTH-1:0]  i_init_data,
  input  logic                  i_init_wen,
  input  logic [NUM_BLOCKS-1:0] i_init_wmask,
  input  logic                  i_init_valid,
  input  logic                  i_init_complete,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [ROW_WIDTH-1:0]  i_req_data,
  input  logic                  i_req_wen,
  input  logic [NUM_BLOCKS-1:0] i_req_wmask,
  output logic                  o_mem_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [ROW_WIDTH-1:0]  o_mem_data,
  output logic                  o_mem_wen,
  output logic [NUM_BLOCKS-1:0] o_mem_wmask,
  input  logic [ROW_WIDTH-1:0]  i_mem_rdata,
  output logic                  o_rsp_valid,
  output logic [ROW_WIDTH-1:0]  o_rsp_data,
  output logic                  o_err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = ADDR_WIDTH + ROW_WIDTH + 1 + NUM_BLOCKS;
  typedef enum logic {INIT, RUN} state_e;
  state_e state_q, state_d;
  logic [CW-1:0] fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0] cnt_q, cnt_d;
  logic [CW-1:0] cmd_q, cmd_d, req_cmd, init_cmd;
  logic en_q, en_d, rd_q, rsp_valid_q, err_q, err_d;
  logic [ROW_WIDTH-1:0] rsp_data_q;
  logic full, empty, run, pop, push, bypass, push_fifo;
  assign init_cmd = {i_init_addr, i_init_data, i_init_wen, i_init_wmask};
  assign req_cmd = {i_req_addr, i_req_data, i_req_wen, i_req_wmask};
  assign {o_mem_addr, o_mem_data, o_mem_wen, o_mem_wmask} = cmd_q;
  assign o_mem_en = en_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data = rsp_data_q;
  assign o_err = err_q;
  always_comb begin
    run = state_q == RUN;
    full = cnt_q == (PW+1)'(FIFO_DEPTH);
    empty = cnt_q == '0;
    pop = run & !empty;
    o_req_ready = !full | pop;
    push = i_req_valid & o_req_ready;
`ifdef STATUS_ARB_BYPASS_EN
    bypass = run & empty & push;
`else
    bypass = 1'b0;
`endif
    push_fifo = push & !bypass;
    state_d = (run | i_init_complete) ? RUN : INIT;
    // the INIT->RUN edge samples neither the init port nor the FIFO
    cmd_d = !run ? (i_init_complete ? cmd_q : init_cmd) : pop ? fifo_q[rd_ptr_q] : bypass ? req_cmd : cmd_q;
    en_d = !run ? (i_init_valid & !i_init_complete) : (pop | bypass);
    cnt_d = cnt_q + (PW+1)'(push_fifo) - (PW+1)'(pop);
    err_d = err_q | (run & i_init_valid);
  end
  always_ff @(posedge gated_clk) begin
    if (push_fifo) fifo_q[wr_ptr_q] <= req_cmd;
  end
  always_ff @(posedge gated_clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      cmd_q <= '0;
      en_q <= 1'b0;
      rd_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push_fifo) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_d;
      cmd_q <= cmd_d;
      en_q <= en_d;
      rd_q <= en_q & !o_mem_wen;
      rsp_valid_q <= rd_q;
      if (rd_q) rsp_data_q <= i_mem_rdata;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_status_array_port_arbiter.sv
// tb_status_array_port_arbiter: scoreboard bench with a behavioural SRAM for status_array_port_arbiter.
module tb_status_array_port_arbiter;
`ifdef STATUS_ARB_BYPASS_EN
  localparam int LAT = 2;
  localparam logic BYP = 1'b1;
`else
  localparam int LAT = 3;
  localparam logic BYP = 1'b0;
`endif
  typedef struct packed {logic [5:0] a; logic [7:0] d; logic w; logic [3:0] m;} cmd_t;
  typedef struct packed {logic w; logic [5:0] a; logic [7:0] d; logic [3:0] m; logic [7:0] e;} vec_t;
  logic gated_clk = 0, arst_n = 0;
  logic [5:0] i_init_addr, i_req_addr, o_mem_addr;
  logic [7:0] i_init_data, i_req_data, o_mem_data, i_mem_rdata, o_rsp_data;
  logic i_init_wen, i_init_valid, i_init_complete, i_req_valid, o_req_ready, i_req_wen;
  logic [3:0] i_init_wmask, i_req_wmask, o_mem_wmask;
  logic o_mem_en, o_mem_wen, o_rsp_valid, o_err;
  logic [7:0] sram [64];
  cmd_t init_q[$], req_q[$];
  logic [7:0] rsp_q[$];
  vec_t tbl [12];
  int checks = 0, fails = 0, k;
  bit acc, in_init, ic_lvl;

  status_array_port_arbiter dut (
    .gated_clk(gated_clk), .arst_n(arst_n),
    .i_init_addr(i_init_addr), .i_init_data(i_init_data), .i_init_wen(i_init_wen),
    .i_init_wmask(i_init_wmask), .i_init_valid(i_init_valid), .i_init_complete(i_init_complete),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .i_req_data(i_req_data), .i_req_wen(i_req_wen), .i_req_wmask(i_req_wmask),
    .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_wen(o_mem_wen), .o_mem_wmask(o_mem_wmask), .i_mem_rdata(i_mem_rdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_err(o_err)
  );

  always #5 gated_clk = ~gated_clk;

  initial begin
    for (int i = 0; i < 64; i++) sram[i] = 8'hXX;
    i_mem_rdata = 8'h00;
  end

  // behavioural SRAM: 2-bit field per wmask bit, read data one cycle after the access
  always @(posedge gated_clk) begin
    if (o_mem_en) begin
      if (o_mem_wen) begin
        for (int b = 0; b < 4; b++) if (o_mem_wmask[b]) sram[o_mem_addr][2*b +: 2] <= o_mem_data[2*b +: 2];
      end else begin
        i_mem_rdata <= sram[o_mem_addr];
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  always @(negedge gated_clk) begin
    if (arst_n) begin
      if (o_mem_en) begin
        if (init_q.size() > 0) chk("issue_init", {o_mem_addr, o_mem_data, o_mem_wen, o_mem_wmask}, init_q.pop_front());
        else if (req_q.size() > 0) chk("issue_req", {o_mem_addr, o_mem_data, o_mem_wen, o_mem_wmask}, req_q.pop_front());
        else chk("spurious_issue", o_mem_en, 0);
      end
      if (o_rsp_valid) begin
        if (rsp_q.size() > 0) chk("rsp_data", o_rsp_data, rsp_q.pop_front());
        else chk("spurious_rsp", o_rsp_valid, 0);
      end
    end
  end

  function automatic cmd_t mk(input logic w, input int a, input int d, input logic [3:0] m);
    return {6'(a), 8'(d), w, m};
  endfunction

  // one clock: drive at a negedge, record expectations, return at the next negedge
  task automatic cyc(input logic iv, input cmd_t ic_c, input logic rv, input cmd_t rc, input logic [7:0] rexp, input int exp_rdy);
    {i_init_addr, i_init_data, i_init_wen, i_init_wmask} = ic_c;
    i_init_valid = iv;
    i_init_complete = ic_lvl;
    {i_req_addr, i_req_data, i_req_wen, i_req_wmask} = rc;
    i_req_valid = rv;
    #1;
    if (exp_rdy >= 0) chk("req_ready", o_req_ready, exp_rdy);
    acc = rv && o_req_ready;
    if (in_init && iv && !ic_lvl) init_q.push_back(ic_c);
    if (acc) begin
      req_q.push_back(rc);
      if (!rc.w) rsp_q.push_back(rexp);
    end
    if (ic_lvl) in_init = 0;
    @(negedge gated_clk);
  endtask

  task automatic idle();
    cyc(0, '0, 0, '0, 0, -1);
  endtask

  task automatic do_reset();
    #2;
    arst_n = 0;
    ic_lvl = 0;
    {i_init_addr, i_init_data, i_init_wen, i_init_wmask, i_init_valid, i_init_complete} = '0;
    {i_req_addr, i_req_data, i_req_wen, i_req_wmask, i_req_valid} = '0;
    #1;
    init_q.delete();
    req_q.delete();
    rsp_q.delete();
    in_init = 1;
    chk("rst_mem", {o_mem_en, o_mem_addr, o_mem_data, o_mem_wen, o_mem_wmask}, 0);
    chk("rst_rsp", {o_rsp_valid, o_rsp_data}, 0);
    chk("rst_err", o_err, 0);
    chk("rst_ready", o_req_ready, 1);
    @(negedge gated_clk);
    @(negedge gated_clk);
    arst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b1, 6'd10, 8'h3C, 4'hF, 8'h00};
    tbl[1]  = '{1'b1, 6'd11, 8'hFF, 4'h5, 8'h00};
    tbl[2]  = '{1'b0, 6'd10, 8'h00, 4'h0, 8'h3C};
    tbl[3]  = '{1'b0, 6'd11, 8'h00, 4'h0, 8'h33};
    tbl[4]  = '{1'b1, 6'd10, 8'h00, 4'h2, 8'h00};
    tbl[5]  = '{1'b0, 6'd10, 8'h00, 4'h0, 8'h30};
    tbl[6]  = '{1'b1, 6'd12, 8'hC3, 4'hF, 8'h00};
    tbl[7]  = '{1'b0, 6'd12, 8'h00, 4'h0, 8'hC3};
    tbl[8]  = '{1'b0, 6'd0,  8'h00, 4'h0, 8'h00};
    tbl[9]  = '{1'b0, 6'd63, 8'h00, 4'h0, 8'h00};
    tbl[10] = '{1'b1, 6'd63, 8'hFF, 4'hF, 8'h00};
    tbl[11] = '{1'b0, 6'd63, 8'h00, 4'h0, 8'hFF};
    do_reset();
    // zero-fill stream mirrored one edge later
    for (int i = 0; i < 64; i++) begin
      cyc(1, mk(1, i, 0, 4'hF), 0, '0, 0, (i == 0) ? 1 : -1);
      chk("init_mirror", {o_mem_en, o_mem_addr}, {1'b1, 6'(i)});
    end
    chk("init_rsp_idle", o_rsp_valid, 0);
    chk("init_err", o_err, 0);
    // three requests during INIT: two fill the FIFO, the third is held
    cyc(0, '0, 1, mk(1, 32, 8'hD0, 4'hF), 0, 1);
    cyc(0, '0, 1, mk(1, 33, 8'hD1, 4'hF), 0, 1);
    cyc(0, '0, 1, mk(1, 34, 8'hD2, 4'hF), 0, 0);
    ic_lvl = 1;
    cyc(1, mk(1, 7, 8'hEE, 4'hF), 1, mk(1, 34, 8'hD2, 4'hF), 0, 0);
    chk("trans_no_access", o_mem_en, 0);
    cyc(0, '0, 1, mk(1, 34, 8'hD2, 4'hF), 0, 1);
    chk("first_drain", o_mem_en, 1);
    // full FIFO with a continuous stream: push and pop every cycle
    for (int i = 0; i < 16; i++) begin
      cyc(0, '0, 1, mk(1, 35 + i, 8'h40 + i, 4'hF), 0, 1);
      chk("stream_en", o_mem_en, 1);
    end
    repeat (4) idle();
    chk("stream_drained", init_q.size() + req_q.size(), 0);
    chk("err_before_run_init", o_err, 0);
    // write then read the same row, exact latency
    cyc(0, '0, 1, mk(1, 5, 8'hA5, 4'hF), 0, 1);
    chk("wr_issue_lat", o_mem_en, BYP);
    cyc(0, '0, 1, mk(0, 5, 0, 4'h0), 8'hA5, 1);
    k = 0;
    while (!o_rsp_valid && k < 8) begin
      idle();
      k++;
    end
    chk("rsp_latency", k, LAT);
    chk("rsp_a5", o_rsp_data, 8'hA5);
    idle();
    chk("rsp_pulse", o_rsp_valid, 0);
    chk("rsp_hold", o_rsp_data, 8'hA5);
    // init port in RUN: no access, sticky error
    cyc(1, mk(1, 5, 0, 4'hF), 0, '0, 0, -1);
    chk("err_set", o_err, 1);
    repeat (3) idle();
    chk("err_sticky", o_err, 1);
    for (int i = 0; i < 12; i++) cyc(0, '0, 1, mk(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].m), tbl[i].e, 1);
    repeat (6) idle();
    chk("table_drained", init_q.size() + req_q.size() + rsp_q.size(), 0);
    // reset mid-drain with queued reads
    do_reset();
    cyc(0, '0, 1, mk(0, 5, 0, 4'h0), 8'hA5, 1);
    cyc(0, '0, 1, mk(0, 10, 0, 4'h0), 8'h30, 1);
    ic_lvl = 1;
    idle();
    chk("drain_wait", o_mem_en, 0);
    idle();
    chk("drain_first", o_mem_en, 1);
    do_reset();
    repeat (5) idle();
    chk("no_rsp_after_rst", o_rsp_valid, 0);
    cyc(1, mk(1, 1, 0, 4'hF), 0, '0, 0, 1);
    chk("init_after_rst", {o_mem_en, o_mem_addr}, {1'b1, 6'd1});
    chk("err_after_rst", o_err, 0);
    repeat (3) idle();
    chk("final_drained", init_q.size() + req_q.size() + rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/status_array_port_arbiter.md
# status_array_port_arbiter

Single-port arbiter in front of the status array SRAM (valid/LRU bits per block). During power-up it forwards the status array initializer's zero-fill write stream to the SRAM and holds cache-controller traffic in a small in-order FIFO. After initialization completes it drains that FIFO and serves controller reads and writes, returning read data on a registered response port.

## Interface
Parameters:
- ADDR_WIDTH, 6, status array row address width
- ROW_WIDTH, 8, status array row width
- NUM_BLOCKS, 4, write-mask width (one bit per block field)
- FIFO_DEPTH, 2, client request FIFO entries; power of 2, ≥2

Ports:
- gated_clk  in  1  clock
- arst_n  in  1  asynchronous, active-low reset
- i_init_addr / i_init_data / i_init_wen / i_init_wmask  in  ADDR_WIDTH / ROW_WIDTH / 1 / NUM_BLOCKS  initializer write command
- i_init_valid  in  1  initializer command valid
- i_init_complete  in  1  initializer done, level
- i_req_valid  in  1  client request valid
- o_req_ready  out  1  client request accepted when valid & ready
- i_req_addr / i_req_data / i_req_wen / i_req_wmask  in  ADDR_WIDTH / ROW_WIDTH / 1 / NUM_BLOCKS  client command
- o_mem_en  out  1  SRAM access enable
- o_mem_addr / o_mem_data / o_mem_wen / o_mem_wmask  out  ADDR_WIDTH / ROW_WIDTH / 1 / NUM_BLOCKS  SRAM command
- i_mem_rdata  in  ROW_WIDTH  SRAM read data, valid one cycle after a read access
- o_rsp_valid  out  1  read response valid, one-cycle pulse
- o_rsp_data  out  ROW_WIDTH  read response data
- o_err  out  1  sticky protocol error

## Operation
- Reset: state INIT; FIFO empty; all o_mem_* 0; o_rsp_valid 0; o_rsp_data 0; o_err 0; o_req_ready 1.
- State INIT:
  - Each edge, the o_mem_* registers load the i_init_* command. o_mem_en equals i_init_valid.
  - Client requests push to the FIFO; o_req_ready = !full.
  - The FIFO is not popped.
- INIT→RUN on the first edge where i_init_complete = 1. No init command is sampled on that edge.
- State RUN:
  - Each edge with the FIFO non-empty pops the head into the o_mem_* registers with o_mem_en = 1.
  - Otherwise o_mem_en = 0; other o_mem_* fields hold their last value.
  - o_req_ready = !full, or full while a pop occurs this cycle (simultaneous push and pop allowed when full).
- RUN is terminal until reset. i_init_valid = 1 in RUN is ignored and sets o_err.
- A push while full (valid & !ready) is dropped by protocol: the client must hold the request. No error is raised.
- Read tracking: a 1-bit flag records o_mem_en & !o_mem_wen. On the following edge, o_rsp_valid = flag and o_rsp_data = i_mem_rdata. o_rsp_data holds when o_rsp_valid = 0.
- Ordering: strictly in acceptance order, so a write followed by a read to the same address returns the written data.
- FIFO pointers: log2(FIFO_DEPTH) bits with modulo wrap. Occupancy counter: log2(FIFO_DEPTH)+1 bits.
- arst_n assertion mid-operation clears the FIFO, any in-flight read flag and o_err, and returns to INIT. Lost requests are not replayed.

## Timing
- Init path: i_init_* sampled at edge N → o_mem_* at N (registered, visible after N).
- Client request accepted at edge N in RUN with an empty FIFO:
  - o_mem_* issued after edge N+1.
  - SRAM reads at N+2.
  - o_rsp_valid high after edge N+3.
- Throughput: one SRAM access per cycle in RUN.
- Requests held in the FIFO during INIT issue starting the edge after the INIT→RUN edge.

## Configuration
- STATUS_ARB_BYPASS_EN defined:
  - In RUN, with the FIFO empty and a request accepted at edge N, the request loads the o_mem_* registers directly at N and skips the FIFO.
  - Issue latency is 1 cycle; read response after edge N+2.
  - When the FIFO is non-empty, the request pushes normally.
- Undefined: all client requests pass through the FIFO; latency is as in Timing.

## Test plan
- Reset then 64 init writes (addr 0..63, wmask 4'hF, data 0) → o_mem_* mirrors each, one cycle later; o_rsp_valid stays 0; o_err 0.
- Three client requests pushed during INIT with FIFO_DEPTH=2 → o_req_ready drops after two; the third is held; after i_init_complete, the three issue on consecutive cycles in order.
- RUN: write addr 5 data 8'hA5, then read addr 5 → o_rsp_valid pulses once with o_rsp_data = 8'hA5 at the stated latency (with and without STATUS_ARB_BYPASS_EN).
- RUN with FIFO full and continuous i_req_valid → simultaneous push/pop each cycle; o_req_ready stays 1; no request lost over 16 cycles; pointers wrap correctly.
- i_init_valid = 1 in RUN → no SRAM access from the init port; o_err = 1 and stays 1.
- arst_n pulsed mid-drain with 2 entries queued → all outputs return to reset values; state INIT; no o_rsp_valid for dropped reads.
